spi_tx_fifo: RTL and testbench

SPI_TX_FIFO -- requirements
Module: spi_tx_fifo

---
 rtl/spi_tx_fifo.sv | 101 ++++++++++
 tb/tb_spi_tx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo.sv
// Transmit FIFO between a write-side producer and an spi_master read port.
// Define SPI_TX_FIFO_THRESH_EN to add the almost_full / almost_empty threshold outputs.
module spi_tx_fifo #(
  parameter int unsigned data_width_g   = 8,
  parameter int unsigned depth_g        = 16
`ifdef SPI_TX_FIFO_THRESH_EN
  ,
  parameter int unsigned almost_full_g  = depth_g - 2,
  parameter int unsigned almost_empty_g = 2
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [data_width_g-1:0]    wr_din,
  input  logic                       wr_din_valid,
  output logic                       full,
  output logic [$clog2(depth_g):0]   used,
  output logic                       overflow,
  input  logic                       fifo_req_data,
  output logic [data_width_g-1:0]    fifo_din,
  output logic                       fifo_din_valid,
  output logic                       fifo_empty,
  output logic                       underflow
`ifdef SPI_TX_FIFO_THRESH_EN
  ,
  output logic                       almost_full,
  output logic                       almost_empty
`endif
);

  localparam int unsigned addr_w = $clog2(depth_g);
  localparam int unsigned used_w = addr_w + 1;

  logic [data_width_g-1:0] r_mem [depth_g];
  logic [addr_w-1:0]       r_wr_ptr;
  logic [addr_w-1:0]       r_rd_ptr;
  logic                    w_rd_acc;
  logic                    w_wr_acc;
  logic [used_w-1:0]       w_used_nxt;

  // A read frees a slot in the same cycle, so a write while full is accepted alongside it.
  assign w_rd_acc = fifo_req_data & ~fifo_empty;
  assign w_wr_acc = wr_din_valid & (~full | w_rd_acc);

  always_comb begin
    w_used_nxt = used;
    if (w_wr_acc && !w_rd_acc) begin
      w_used_nxt = used + used_w'(1);
    end else if (w_rd_acc && !w_wr_acc) begin
      w_used_nxt = used - used_w'(1);
    end
  end

  // Storage is left uninitialised; only the pointers and counter are cleared.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      used           <= '0;
      full           <= 1'b0;
      fifo_empty     <= 1'b1;
      fifo_din       <= '0;
      fifo_din_valid <= 1'b0;
      overflow       <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + addr_w'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + addr_w'(1);
        fifo_din <= r_mem[r_rd_ptr];
      end
      fifo_din_valid <= w_rd_acc;
      overflow       <= wr_din_valid & ~w_wr_acc;
      underflow      <= fifo_req_data & fifo_empty;
      used           <= w_used_nxt;
      full           <= (w_used_nxt == used_w'(depth_g));
      fifo_empty     <= (w_used_nxt == '0);
    end
  end

`ifdef SPI_TX_FIFO_THRESH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (w_used_nxt >= used_w'(almost_full_g));
      almost_empty <= (w_used_nxt <= used_w'(almost_empty_g));
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Self-checking bench for spi_tx_fifo: queue-based reference model plus directed literal checks.
// Build with SPI_TX_FIFO_THRESH_EN defined to also cover the threshold outputs.
module tb_spi_tx_fifo;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] wr_din;
  logic       wr_din_valid;
  logic       full;
  logic [4:0] used;
  logic       overflow;
  logic       fifo_req_data;
  logic [7:0] fifo_din;
  logic       fifo_din_valid;
  logic       fifo_empty;
  logic       underflow;
`ifdef SPI_TX_FIFO_THRESH_EN
  logic       almost_full;
  logic       almost_empty;
`endif

  spi_tx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .wr_din         (wr_din),
    .wr_din_valid   (wr_din_valid),
    .full           (full),
    .used           (used),
    .overflow       (overflow),
    .fifo_req_data  (fifo_req_data),
    .fifo_din       (fifo_din),
    .fifo_din_valid (fifo_din_valid),
    .fifo_empty     (fifo_empty),
    .underflow      (underflow)
`ifdef SPI_TX_FIFO_THRESH_EN
    ,
    .almost_full    (almost_full),
    .almost_empty   (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] mq[$];
  logic [7:0] rx[$];
  logic [7:0] e_din;
  logic       e_val;
  logic       e_ovf;
  logic       e_unf;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then compare every output after the edge.
  task automatic drive(input logic r, input logic wv, input logic [7:0] d, input logic rq);
    logic rd;
    logic wr;
    rst           = r;
    wr_din_valid  = wv;
    wr_din        = d;
    fifo_req_data = rq;
    if (r) begin
      mq.delete();
      e_din = 8'h00;
      e_val = 1'b0;
      e_ovf = 1'b0;
      e_unf = 1'b0;
    end else begin
      rd    = rq && (mq.size() != 0);
      wr    = wv && ((mq.size() < DEPTH) || rd);
      e_unf = rq && (mq.size() == 0);
      e_ovf = wv && !wr;
      e_val = rd;
      if (rd) e_din = mq.pop_front();
      if (wr) mq.push_back(d);
    end
    @(negedge clk);
    #1;
    chk("used",           int'(used),           mq.size());
    chk("full",           int'(full),           int'(mq.size() == DEPTH));
    chk("fifo_empty",     int'(fifo_empty),     int'(mq.size() == 0));
    chk("fifo_din_valid", int'(fifo_din_valid), int'(e_val));
    chk("fifo_din",       int'(fifo_din),       int'(e_din));
    chk("overflow",       int'(overflow),       int'(e_ovf));
    chk("underflow",      int'(underflow),      int'(e_unf));
`ifdef SPI_TX_FIFO_THRESH_EN
    chk("almost_full",    int'(almost_full),    int'(mq.size() >= DEPTH - 2));
    chk("almost_empty",   int'(almost_empty),   int'(mq.size() <= 2));
`endif
    if (fifo_din_valid) rx.push_back(fifo_din);
  endtask

  initial begin
    int n_ee;
    rst = 1'b1; wr_din_valid = 1'b0; wr_din = 8'h00; fifo_req_data = 1'b0;

    // reset, with traffic that must be ignored
    drive(1, 0, 8'h00, 0);
    drive(1, 1, 8'h99, 1);
    chk("lit_rst_used", int'(used), 0);
    chk("lit_rst_empty", int'(fifo_empty), 1);
    chk("lit_rst_din", int'(fifo_din), 0);
    drive(0, 0, 8'h00, 0);
    chk("lit_rst_write_dropped", int'(used), 0);

    // three writes, three back-to-back reads
    rx.delete();
    drive(0, 1, 8'h11, 0);
    drive(0, 1, 8'h22, 0);
    drive(0, 1, 8'h33, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1);
    chk("lit_seq_count", rx.size(), 3);
    if (rx.size() == 3) begin
      chk("lit_seq_w0", int'(rx[0]), 'h11);
      chk("lit_seq_w1", int'(rx[1]), 'h22);
      chk("lit_seq_w2", int'(rx[2]), 'h33);
    end
    chk("lit_seq_empty", int'(fifo_empty), 1);
    chk("lit_seq_used", int'(used), 0);

    // underflow, then write+request on empty
    drive(0, 0, 8'h00, 1);
    chk("lit_unf_pulse", int'(underflow), 1);
    chk("lit_unf_valid", int'(fifo_din_valid), 0);
    drive(0, 1, 8'hA5, 1);
    chk("lit_wr_unf_used", int'(used), 1);
    chk("lit_wr_unf_pulse", int'(underflow), 1);
    drive(0, 0, 8'h00, 1);
    chk("lit_a5_valid", int'(fifo_din_valid), 1);
    chk("lit_a5_data", int'(fifo_din), 'hA5);

    // fill to full, overflow on the 17th write
    for (int i = 0; i < 16; i++) drive(0, 1, 8'(8'h40 + i), 0);
    chk("lit_full", int'(full), 1);
    chk("lit_full_used", int'(used), 16);
    drive(0, 1, 8'hEE, 0);
    chk("lit_ovf_pulse", int'(overflow), 1);
    chk("lit_ovf_used", int'(used), 16);
    drive(0, 0, 8'h00, 0);
    chk("lit_ovf_one_cycle", int'(overflow), 0);

    // write and read together while full, then drain across the pointer wrap
    rx.delete();
    drive(0, 1, 8'h5A, 1);
    chk("lit_wr_rd_full_used", int'(used), 16);
    chk("lit_wr_rd_full_head", int'(fifo_din), 'h40);
    for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    chk("lit_drain_count", rx.size(), 17);
    if (rx.size() == 17) begin
      chk("lit_drain_w15", int'(rx[15]), 'h4F);
      chk("lit_drain_last", int'(rx[16]), 'h5A);
    end
    n_ee = 0;
    foreach (rx[i]) if (rx[i] == 8'hEE) n_ee++;
    chk("lit_dropped_never_read", n_ee, 0);

    // reset with five words stored and a read in flight
    for (int i = 0; i < 5; i++) drive(0, 1, 8'(8'h10 + i), 0);
    drive(0, 0, 8'h00, 1);
    drive(1, 1, 8'h99, 1);
    chk("lit_mid_rst_empty", int'(fifo_empty), 1);
    chk("lit_mid_rst_used", int'(used), 0);
    chk("lit_mid_rst_valid", int'(fifo_din_valid), 0);
    drive(0, 0, 8'h00, 0);
    rx.delete();
    drive(0, 1, 8'h77, 0);
    drive(0, 0, 8'h00, 1);
    drive(0, 0, 8'h00, 1);
    chk("lit_post_rst_count", rx.size(), 1);
    if (rx.size() == 1) chk("lit_post_rst_data", int'(rx[0]), 'h77);

`ifdef SPI_TX_FIFO_THRESH_EN
    // thresholds at their default settings
    for (int i = 0; i < 13; i++) drive(0, 1, 8'(i), 0);
    chk("lit_af_13", int'(almost_full), 0);
    drive(0, 1, 8'hD0, 0);
    chk("lit_af_14", int'(almost_full), 1);
    for (int i = 0; i < 11; i++) drive(0, 0, 8'h00, 1);
    chk("lit_ae_3", int'(almost_empty), 0);
    drive(0, 0, 8'h00, 1);
    chk("lit_ae_2", int'(almost_empty), 1);
    chk("lit_ae_used", int'(used), 2);
`endif

    // mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 150) == 0), 1'($urandom_range(0, 1)),
            8'($urandom), 1'($urandom_range(0, 2) == 0 ? (i / 100) % 2 : 1));
    end
    for (int i = 0; i < 20; i++) drive(0, 0, 8'h00, 1);
    chk("lit_final_empty", int'(fifo_empty), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
